// File: rtl/zmips_ex_stage_if.sv
// Bus interfaces around the zMIPS execute stage: ID->EX instruction transfer
// and the EX/MEM pipeline register handshake toward MEM.

interface zmips_id_ex_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_wr_en;

    modport master (
        output id_valid, id_rs_val, id_rt_val, id_imm, id_use_imm,
               id_alu_op, id_rs, id_rt, id_rd, id_wr_en,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rs_val, id_rt_val, id_imm, id_use_imm,
               id_alu_op, id_rs, id_rt, id_rd, id_wr_en,
        output id_ready
    );
endinterface

interface zmips_ex_mem_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_wr_en;
    logic        ex_zero;
    logic        ex_cout;
    logic        ex_illegal;

    modport master (
        output ex_valid, ex_result, ex_rd, ex_wr_en, ex_zero, ex_cout, ex_illegal,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_result, ex_rd, ex_wr_en, ex_zero, ex_cout, ex_illegal,
        output ex_ready
    );
endinterface

// File: rtl/zmips_ex_stage.sv
// zMIPS execute stage: operand forwarding into an external combinational ALU,
// result captured in a single-entry EX/MEM register with valid/ready handshake.

module zmips_ex_stage (
    input  logic                  clk,
    input  logic                  rst_n,
    zmips_id_ex_if.slave          id_bus,
    zmips_ex_mem_if.master        ex_bus,
    input  logic                  flush,
    input  logic                  wb_fwd_en,
    input  logic [4:0]            wb_fwd_rd,
    input  logic [31:0]           wb_fwd_data,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_op,
    input  logic [31:0]           alu_y,
    input  logic                  alu_zero,
    input  logic                  alu_cout
);

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr_en;
        logic        zero;
        logic        cout;
        logic        illegal;
    } ex_reg_t;

    ex_reg_t ex_q;
    logic    ex_valid_q;
    logic    accept;
    logic    illegal;

    // EX/MEM has priority over WB because it is the younger producer; r0 is hardwired.
    function automatic logic [31:0] forward(
        input logic [4:0]  idx,
        input logic [31:0] rf_val,
        input logic        ex_hit_ok,
        input ex_reg_t     ex,
        input logic        wb_en,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        if (idx == 5'd0)
            return rf_val;
        else if (ex_hit_ok && ex.wr_en && ex.rd == idx)
            return ex.result;
        else if (wb_en && wb_rd == idx)
            return wb_data;
        else
            return rf_val;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        illegal = 1'b1;
        case (id_bus.id_alu_op)
            4'h0, 4'h1, 4'h4, 4'h8, 4'hC: illegal = 1'b0;
            default:                      illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_a = forward(id_bus.id_rs, id_bus.id_rs_val, ex_valid_q, ex_q,
                        wb_fwd_en, wb_fwd_rd, wb_fwd_data);
        if (id_bus.id_use_imm)
            alu_b = id_bus.id_imm;
        else
            alu_b = forward(id_bus.id_rt, id_bus.id_rt_val, ex_valid_q, ex_q,
                            wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    end

    assign alu_op           = id_bus.id_alu_op;
    assign id_bus.id_ready  = ~ex_valid_q | ex_bus.ex_ready;
    assign accept           = id_bus.id_valid & id_bus.id_ready & ~flush;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: data fields are plain flops, not a memory, so resetting them is cheap and keeps outputs clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            ex_q.wr_en <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_q       <= '{result:  alu_y,
                            rd:      id_bus.id_rd,
                            wr_en:   id_bus.id_wr_en & ~illegal,
                            zero:    alu_zero,
                            cout:    alu_cout,
                            illegal: illegal};
        end else if (ex_bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_bus.ex_valid   = ex_valid_q;
    assign ex_bus.ex_result  = ex_q.result;
    assign ex_bus.ex_rd      = ex_q.rd;
    assign ex_bus.ex_wr_en   = ex_q.wr_en;
    assign ex_bus.ex_zero    = ex_q.zero;
    assign ex_bus.ex_cout    = ex_q.cout;
    assign ex_bus.ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_zmips_ex_stage.sv
// Scoreboard bench for zmips_ex_stage: a driver predicts each accepted
// instruction from an architectural model, a monitor checks it at MEM handoff.

module tb_zmips_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_cout;
  logic [32:0] alu_sum;

  zmips_id_ex_if  id_bus ();
  zmips_ex_mem_if ex_bus ();

  zmips_ex_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_bus      (id_bus),
    .ex_bus      (ex_bus),
    .flush       (flush),
    .wb_fwd_en   (wb_fwd_en),
    .wb_fwd_rd   (wb_fwd_rd),
    .wb_fwd_data (wb_fwd_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_y       (alu_y),
    .alu_zero    (alu_zero),
    .alu_cout    (alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for zmips_alu; illegal opcodes yield zero.
  always_comb begin
    alu_sum = '0;
    case (alu_op)
      4'h0:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1:    alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      4'h4:    alu_sum = {1'b0, alu_a & alu_b};
      4'h8:    alu_sum = {1'b0, alu_a | alu_b};
      4'hC:    alu_sum = {1'b0, alu_a ^ alu_b};
      default: alu_sum = '0;
    endcase
    alu_y    = alu_sum[31:0];
    alu_cout = alu_sum[32];
    alu_zero = (alu_sum[31:0] == 32'd0);
  end

  typedef struct {
    bit          valid;
    logic [31:0] rs_val, rt_val, imm;
    bit          use_imm;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    bit          wr_en, flush, wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    bit          ex_ready;
  } stim_t;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    bit          wr_en, zero, cout, illegal;
  } exp_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb_q[$];

  // Architectural view of the instruction still pending in EX/MEM.
  bit          m_valid, m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_res;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.ex_ready = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
    if (idx == 0) return rf;
    if (m_valid && m_wr && m_rd == idx) return m_res;
    if (s.wb_en && s.wb_rd == idx) return s.wb_data;
    return rf;
  endfunction

  function automatic exp_t ref_exec(input logic [31:0] a, input logic [31:0] b, input stim_t s);
    exp_t e;
    logic [63:0] wide;
    e = '{default: '0};
    case (s.op)
      4'h0: begin wide = 64'(a) + 64'(b); e.result = wide[31:0]; e.cout = wide[32]; end
      4'h1: begin e.result = a - b; e.cout = (a >= b); end
      4'h4: e.result = a & b;
      4'h8: e.result = a | b;
      4'hC: e.result = a ^ b;
      default: e.illegal = 1'b1;
    endcase
    e.zero  = (e.result == 0);
    e.rd    = s.rd;
    e.wr_en = s.wr_en && !e.illegal;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    id_bus.id_valid   = s.valid;
    id_bus.id_rs_val  = s.rs_val;
    id_bus.id_rt_val  = s.rt_val;
    id_bus.id_imm     = s.imm;
    id_bus.id_use_imm = s.use_imm;
    id_bus.id_alu_op  = s.op;
    id_bus.id_rs      = s.rs;
    id_bus.id_rt      = s.rt;
    id_bus.id_rd      = s.rd;
    id_bus.id_wr_en   = s.wr_en;
    flush             = s.flush;
    wb_fwd_en         = s.wb_en;
    wb_fwd_rd         = s.wb_rd;
    wb_fwd_data       = s.wb_data;
    ex_bus.ex_ready   = s.ex_ready;
  endtask

  // One clock: entered and left just after a rising edge.
  task automatic cycle(input stim_t s);
    logic [31:0] a, b;
    bit          exp_ready, accept;
    exp_t        e;
    drive(s);
    @(negedge clk);
    exp_ready = !m_valid || s.ex_ready;
    a = ref_operand(s.rs, s.rs_val, s);
    b = s.use_imm ? s.imm : ref_operand(s.rt, s.rt_val, s);
    check("id_ready", id_bus.id_ready, exp_ready);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, s.op);
    accept = s.valid && exp_ready && !s.flush;
    e = ref_exec(a, b, s);
    if (accept) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (s.flush) begin
      m_valid = 1'b0;
      m_wr    = 1'b0;
    end else if (accept) begin
      m_valid = 1'b1;
      m_wr    = e.wr_en;
      m_rd    = e.rd;
      m_res   = e.result;
    end else if (s.ex_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: compares at MEM handoff; a flush during a stall discards the entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ex_bus.ex_valid) begin
        check("sb_has_item", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          if (ex_bus.ex_ready) begin
            e = sb_q.pop_front();
            check("ex_result",  ex_bus.ex_result,  e.result);
            check("ex_rd",      ex_bus.ex_rd,      e.rd);
            check("ex_wr_en",   ex_bus.ex_wr_en,   e.wr_en);
            check("ex_zero",    ex_bus.ex_zero,    e.zero);
            check("ex_cout",    ex_bus.ex_cout,    e.cout);
            check("ex_illegal", ex_bus.ex_illegal, e.illegal);
          end else if (flush) begin
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [3:0] ops[5] = '{4'h0, 4'h1, 4'h4, 4'h8, 4'hC};
    m_valid = 0; m_wr = 0; m_rd = 0; m_res = 0;
    drive(idle());
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   ex_bus.ex_valid,   0);
    check("rst_result",  ex_bus.ex_result,  0);
    check("rst_wr_en",   ex_bus.ex_wr_en,   0);
    check("rst_illegal", ex_bus.ex_illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_id_ready", id_bus.id_ready, 1);
    @(posedge clk);
    #1;

    // ADD r3 = 5 + 7
    s = idle(); s.valid = 1; s.rs = 1; s.rs_val = 5; s.rt = 2; s.rt_val = 7;
    s.op = 4'h0; s.rd = 3; s.wr_en = 1;
    cycle(s);
    check("add_valid", ex_bus.ex_valid, 1);
    check("add_result", ex_bus.ex_result, 12);
    check("add_rd", ex_bus.ex_rd, 3);

    // SUB r3 - 12 with stale register-file rs
    s = idle(); s.valid = 1; s.rs = 3; s.rs_val = 0; s.rt = 5; s.rt_val = 12;
    s.op = 4'h1; s.rd = 6; s.wr_en = 1;
    cycle(s);
    check("sub_result", ex_bus.ex_result, 0);
    check("sub_zero", ex_bus.ex_zero, 1);
    check("sub_cout", ex_bus.ex_cout, 1);

    // r4 = 0xAAAA0000 in EX/MEM, WB writes r4 = 0x1234; EX/MEM wins
    s = idle(); s.valid = 1; s.use_imm = 1; s.imm = 32'hAAAA_0000;
    s.op = 4'h8; s.rd = 4; s.wr_en = 1;
    cycle(s);
    s = idle(); s.valid = 1; s.rs = 4; s.rt = 4; s.op = 4'h8; s.rd = 7; s.wr_en = 1;
    s.wb_en = 1; s.wb_rd = 4; s.wb_data = 32'h1234;
    cycle(s);
    check("prio_result", ex_bus.ex_result, 32'hAAAA_0000);

    // r0 is never forwarded, even with a WB write to r0
    s = idle(); s.valid = 1; s.rs = 0; s.rs_val = 32'h55; s.use_imm = 1; s.imm = 1;
    s.op = 4'h0; s.rd = 8; s.wr_en = 1; s.wb_en = 1; s.wb_rd = 0; s.wb_data = 32'hFFFF;
    cycle(s);
    check("r0_result", ex_bus.ex_result, 32'h56);

    // Stall three cycles, then release
    s = idle(); s.valid = 1; s.rs = 9; s.rs_val = 100; s.rt = 10; s.rt_val = 200;
    s.op = 4'h0; s.rd = 9; s.wr_en = 1; s.ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(s);
      check("stall_valid", ex_bus.ex_valid, 1);
      check("stall_result", ex_bus.ex_result, 32'h56);
      check("stall_rd", ex_bus.ex_rd, 8);
    end
    s.ex_ready = 1;
    cycle(s);
    check("release_result", ex_bus.ex_result, 300);

    // Flush while holding and offered a new instruction
    s = idle(); s.valid = 1; s.rs = 1; s.rs_val = 1; s.op = 4'h0; s.rd = 12;
    s.wr_en = 1; s.ex_ready = 0; s.flush = 1;
    cycle(s);
    check("flush_valid", ex_bus.ex_valid, 0);
    check("flush_wr_en", ex_bus.ex_wr_en, 0);

    // Illegal opcode 2
    s = idle(); s.valid = 1; s.op = 4'h2; s.rd = 11; s.wr_en = 1;
    cycle(s);
    check("illegal_flag", ex_bus.ex_illegal, 1);
    check("illegal_wr_en", ex_bus.ex_wr_en, 0);

    // Async reset in the middle of a stall
    s = idle(); s.valid = 1; s.op = 4'h0; s.rd = 13; s.wr_en = 1; s.ex_ready = 0;
    cycle(s);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",   ex_bus.ex_valid,   0);
    check("arst_result",  ex_bus.ex_result,  0);
    check("arst_rd",      ex_bus.ex_rd,      0);
    check("arst_wr_en",   ex_bus.ex_wr_en,   0);
    check("arst_zero",    ex_bus.ex_zero,    0);
    check("arst_cout",    ex_bus.ex_cout,    0);
    check("arst_illegal", ex_bus.ex_illegal, 0);
    sb_q.delete();
    m_valid = 0; m_wr = 0;
    drive(idle());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with a small register window to provoke forwarding
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.valid    = ($urandom % 4) != 0;
      s.rs       = 5'($urandom_range(0, 7));
      s.rt       = 5'($urandom_range(0, 7));
      s.rd       = 5'($urandom_range(0, 7));
      s.rs_val   = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 20));
      s.rt_val   = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 20));
      s.imm      = $urandom;
      s.use_imm  = ($urandom % 4) == 0;
      s.op       = (($urandom % 10) == 0) ? 4'($urandom) : ops[$urandom % 5];
      s.wr_en    = ($urandom % 5) != 0;
      s.flush    = ($urandom % 16) == 0;
      s.wb_en    = $urandom % 2;
      s.wb_rd    = 5'($urandom_range(0, 7));
      s.wb_data  = $urandom;
      s.ex_ready = ($urandom % 4) != 0;
      cycle(s);
    end

    for (int i = 0; i < 3; i++) cycle(idle());
    check("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
